// File: rtl/ext_irq_ctrl.sv
// ext_irq_ctrl: synchronizes external interrupt lines, latches pending bits and presents the lowest pending line to the core
//   Clk, Rst             clock, synchronous active-high reset
//   i_ext                asynchronous external interrupt lines
//   cfg_we/addr/wdata    config write port: 0 ENABLE, 1 MODE (1=edge), 2 POL (1=rising/high), 3 PENDING (write-1-to-clear)
//   cfg_rdata            combinational read of the register at cfg_addr
//   irq_req, irq_id      registered request and line index to the core
//   irq_ack, irq_done    core accept and end-of-handler pulses
module ext_irq_ctrl #(
  parameter int N_IRQ = 31,
  parameter int ID_W  = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [N_IRQ-1:0] i_ext,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_ack,
  input  logic             irq_done
);
  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_SVC = 2'd2;
  logic [N_IRQ-1:0] s1, s2, s3, en, mode, pol, pend, pend_nx, det, act, w1c, ack_clr, cand;
  logic [1:0] state;
  logic [ID_W-1:0] win;
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata[31:N_IRQ];
  assign irq_req = state == S_REQ;
  always_comb begin
    det = (pol & s2 & ~s3) | (~pol & ~s2 & s3);
    act = ~(s2 ^ pol);
    w1c = (cfg_we && cfg_addr == 2'd3) ? cfg_wdata[N_IRQ-1:0] : '0;
    // only the acked line is cleared, and only if it is an edge line
    ack_clr = (irq_req && irq_ack && mode[irq_id]) ? N_IRQ'(1) << irq_id : '0;
    // edge lines: sticky, new detect beats any clear in the same cycle; level lines: follow the input
    pend_nx = (mode & ((pend & ~w1c & ~ack_clr) | (det & en))) | (~mode & act & en);
    cand = pend & en;
    win = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) win = cand[i] ? ID_W'(i) : win;
    cfg_rdata = cfg_addr == 2'd0 ? 32'(en) :
                cfg_addr == 2'd1 ? 32'(mode) :
                cfg_addr == 2'd2 ? 32'(pol) : 32'(pend);
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      en <= '0;
      mode <= '0;
      pol <= '0;
      pend <= '0;
      state <= S_IDLE;
      irq_id <= '0;
    end else begin
      s1 <= i_ext;
      s2 <= s1;
      s3 <= s2;
      if (cfg_we && cfg_addr == 2'd0) en <= cfg_wdata[N_IRQ-1:0];
      if (cfg_we && cfg_addr == 2'd1) mode <= cfg_wdata[N_IRQ-1:0];
      if (cfg_we && cfg_addr == 2'd2) pol <= cfg_wdata[N_IRQ-1:0];
      pend <= pend_nx;
      state <= state == S_IDLE ? (|cand ? S_REQ : S_IDLE) :
               state == S_REQ  ? (irq_ack ? S_SVC : S_REQ) :
                                 (irq_done ? S_IDLE : S_SVC);
      if (state == S_IDLE && |cand) irq_id <= win;
    end
  end
endmodule

// File: doc/ext_irq_ctrl.md
# ext_irq_ctrl

External interrupt controller: the receiving end of the SoC's `i_ext[30:0]` interrupt lines. It synchronizes each line, detects the configured edge or level, and latches a pending bit per line. It presents the lowest-numbered pending, enabled line to the CPU core through a req/ack/done handshake. Sits inside `soc` between the top-level `i_ext` pins and the core's interrupt input, with a 4-register config port on the peripheral bus.

## Interface
- `N_IRQ`, 31: number of external lines (1..31)
- `ID_W`, 5: width of `irq_id`
- `Clk`  in  1  system clock; all logic on rising edge
- `Rst`  in  1  synchronous, active-high reset
- `i_ext`  in  N_IRQ  asynchronous external interrupt lines
- `cfg_we`  in  1  config write strobe, one cycle
- `cfg_addr`  in  2  register select: 0 ENABLE, 1 MODE, 2 POL, 3 PENDING
- `cfg_wdata`  in  32  write data; bits [N_IRQ-1:0] used
- `cfg_rdata`  out  32  read data for `cfg_addr`, combinational; unused bits 0
- `irq_req`  out  1  interrupt request to core
- `irq_id`  out  ID_W  index of the requested line, valid while `irq_req`=1
- `irq_ack`  in  1  core accepts request, one-cycle pulse
- `irq_done`  in  1  core finished handler (RETI), one-cycle pulse

## Operation
- Registers (R/W unless noted), all 0 after reset:
  - ENABLE: 1 = line may set pending.
  - MODE: 1 = edge, 0 = level.
  - POL: 1 = rising/high, 0 = falling/low.
  - PENDING: read = pending bits; write = write-1-to-clear.
- Input path per line: `s1`←`i_ext`, `s2`←`s1`, `s3`←`s2`; all reset to 0. Minimum guaranteed-captured pulse width is 2 `Clk` periods; shorter pulses may be lost.
- Detect, per line:
  - Edge mode: rising = `s2&~s3`; falling = `~s2&s3`.
  - Level mode: active = `s2==POL`.
- PENDING bit behaviour:
  - Edge mode: set on detect while ENABLE=1; sticky until cleared by W1C or by ack of that line.
  - Level mode: equals `active & ENABLE` every cycle; W1C and ack have no effect.
- Priority: lowest index among `PENDING & ENABLE`.
- FSM states IDLE, REQ, SERVICE. Reset → IDLE.
  - IDLE: if any pending & enabled → REQ; latch `irq_id` = priority winner.
  - REQ: `irq_req`=1, `irq_id` held stable. On `irq_ack` → SERVICE and clear PENDING[`irq_id`] if that line is edge mode.
  - SERVICE: `irq_req`=0; new pending lines accumulate but are not presented (no nesting). On `irq_done` → IDLE.
- Boundary rules:
  - `irq_ack` outside REQ and `irq_done` outside SERVICE are ignored.
  - Set and W1C on the same bit in the same cycle: set wins.
  - New edge on line k in the same cycle as ack of k: pending stays 1.
  - Disabling or clearing the line currently in REQ does not withdraw `irq_req`/`irq_id`; the core still acks. Ack then clears nothing extra.
  - A level line still active after `irq_done` re-requests from IDLE.
  - MODE/POL writes take effect next cycle. Changing POL on an edge line may itself generate one detect; software clears PENDING after reconfiguring.
  - `Rst` mid-operation: next edge all registers, sync stages and FSM return to reset values; `irq_req`=0, `irq_id`=0, `cfg_rdata` reflects zeros.

## Timing
- `i_ext` change sampled at edge k: `s2` at k+1, PENDING set at k+2, REQ and `irq_req`=1 at k+3 (FSM in IDLE).
- `irq_ack` sampled at edge a: `irq_req`=0 and pending cleared from a+1.
- `irq_done` at edge d: IDLE at d+1; earliest next `irq_req` at d+2.
- Config write at edge w: register visible on `cfg_rdata` from w+1.
- `irq_req` and `irq_id` are registered outputs; no combinational path from `i_ext` or `cfg_*` to them.

## Test plan
- Reset, then ENABLE=0x2, MODE=0x2, POL=0x0; `i_ext[1]` high for 5 cycles then low → `irq_req`=1, `irq_id`=1, 3 cycles after the falling edge is sampled. Ack → PENDING=0; done → IDLE, no re-request.
- Same config, `i_ext[1]` pulse of 2 ns → no capture required, no X. Pulse of 2 cycles → captured.
- ENABLE=0x7FFFFFFF, all rising edge; lines 4 and 9 rise in the same cycle → `irq_id`=4 first. After ack/done, `irq_id`=9.
- Line 3 level-high: hold high through ack and done → `irq_req` reasserts at d+2 with `irq_id`=3. Drop the line → PENDING[3]=0 next-but-two cycle.
- Edge on line 0 in the same cycle as a W1C of bit 0 → PENDING[0] reads 1. Edge on line 0 during ack of line 0 → re-request after done.
- Assert `Rst` for one cycle while in SERVICE with PENDING=0x10 → all outputs 0, FSM IDLE, config registers 0, and no request afterwards.
